// File: rtl/dma_prog_if.sv
// Host programming port of an 8237A-style DMA: register decode, architectural state, TC/update merge.
// Writes commit on the first clock of a strobe; the byte pointer advances when the strobe is released.
module dma_prog_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cs_n,
   input  logic                     ior_n,
   input  logic                     iow_n,
   input  logic [3:0]               addr,
   input  logic [7:0]               db_in,
   output logic [7:0]               db_out,
   output logic                     db_oe,
   input  logic [NUM_CH-1:0]        dreq_live,
   input  logic [7:0]               temp_in,
   input  logic [NUM_CH-1:0]        tc_pulse,
   input  logic                     upd_en,
   input  logic [1:0]               upd_ch,
   input  logic [ADDR_W-1:0]        upd_addr,
   input  logic [ADDR_W-1:0]        upd_count,
   output logic [7:0]               cmd_reg,
   output logic [NUM_CH*6-1:0]      mode_reg,
   output logic [NUM_CH-1:0]        mask_reg,
   output logic [NUM_CH-1:0]        req_reg,
   output logic [NUM_CH*ADDR_W-1:0] curr_addr,
   output logic [NUM_CH*ADDR_W-1:0] curr_count,
   output logic                     mclr_pulse
);

   typedef logic [ADDR_W-1:0] word_t;

   logic wr_v, rd_v, wr_start, rd_start, wr_end, rd_end;
   logic wr_q, rd_q, db_oe_q, db_oe_d, byte_ff_q, byte_ff_d, mclr_q, mclr_d;
   logic [3:0] acc_addr_q, acc_addr_d;
   logic [7:0] cmd_q, cmd_d, rd_dat;
   logic [NUM_CH-1:0] mask_q, mask_d, req_q, req_d, tc_stat_q, tc_stat_d;
   logic [NUM_CH-1:0][5:0] mode_q, mode_d;
   logic [NUM_CH-1:0][ADDR_W-1:0] base_addr_q, base_addr_d, base_cnt_q, base_cnt_d;
   logic [NUM_CH-1:0][ADDR_W-1:0] curr_addr_q, curr_addr_d, curr_cnt_q, curr_cnt_d;
   word_t rd_word;

   // Simultaneous read and write strobes are treated as no access at all.
   assign wr_v     = ~cs_n & ~iow_n & ~(~cs_n & ~ior_n);
   assign rd_v     = ~cs_n & ~ior_n & ~(~cs_n & ~iow_n);
   assign wr_start = wr_v & ~wr_q;
   assign rd_start = rd_v & ~rd_q;
   assign wr_end   = ~wr_v & wr_q;
   assign rd_end   = ~rd_v & rd_q;

   function automatic word_t put_byte(word_t v, logic hi, logic [7:0] b);
      word_t r;
      r = v;
      if (hi) r[15:8] = b;
      else    r[7:0]  = b;
      return r;
   endfunction

   always_comb begin
      cmd_d       = cmd_q;
      mask_d      = mask_q;
      req_d       = req_q;
      tc_stat_d   = tc_stat_q;
      mode_d      = mode_q;
      base_addr_d = base_addr_q;
      base_cnt_d  = base_cnt_q;
      curr_addr_d = curr_addr_q;
      curr_cnt_d  = curr_cnt_q;
      byte_ff_d   = byte_ff_q;
      mclr_d      = 1'b0;
      db_oe_d     = rd_v;
      acc_addr_d  = (wr_start | rd_start) ? addr : acc_addr_q;

      if ((wr_end | rd_end) && !acc_addr_q[3]) byte_ff_d = ~byte_ff_q;
      if (rd_end && acc_addr_q == 4'h8) tc_stat_d = '0;

      // Lowest priority first: core update, then TC reload; host writes below override both.
      for (int i = 0; i < NUM_CH; i++) begin
         if (upd_en && upd_ch == 2'(i)) begin
            curr_addr_d[i] = upd_addr;
            curr_cnt_d[i]  = upd_count;
         end
         if (tc_pulse[i]) begin
            tc_stat_d[i] = 1'b1;
            req_d[i]     = 1'b0;
            if (mode_q[i][2]) begin
               curr_addr_d[i] = base_addr_q[i];
               curr_cnt_d[i]  = base_cnt_q[i];
            end else begin
               mask_d[i] = 1'b1;
            end
         end
      end

      if (wr_start) begin
         if (!addr[3]) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (addr[2:1] == 2'(i)) begin
                  if (addr[0]) begin
                     base_cnt_d[i] = put_byte(base_cnt_q[i], byte_ff_q, db_in);
                     curr_cnt_d[i] = put_byte(curr_cnt_q[i], byte_ff_q, db_in);
                  end else begin
                     base_addr_d[i] = put_byte(base_addr_q[i], byte_ff_q, db_in);
                     curr_addr_d[i] = put_byte(curr_addr_q[i], byte_ff_q, db_in);
                  end
               end
            end
         end else begin
            case (addr[2:0])
               3'd0: cmd_d = db_in;
               3'd1: req_d[db_in[1:0]] = db_in[2];
               3'd2: mask_d[db_in[1:0]] = db_in[2];
               3'd3: mode_d[db_in[1:0]] = db_in[7:2];
               3'd4: byte_ff_d = 1'b0;
               3'd5: begin
                  cmd_d     = '0;
                  req_d     = '0;
                  tc_stat_d = '0;
                  mask_d    = '1;
                  byte_ff_d = 1'b0;
                  mclr_d    = 1'b1;
               end
               3'd6: mask_d = '0;
               default: mask_d = db_in[NUM_CH-1:0];
            endcase
         end
      end
   end

   always_comb begin
      rd_word = addr[0] ? curr_cnt_q[addr[2:1]] : curr_addr_q[addr[2:1]];
      rd_dat  = 8'h00;
      if (!addr[3])           rd_dat = byte_ff_q ? rd_word[15:8] : rd_word[7:0];
      else if (addr == 4'h8)  rd_dat = {dreq_live, tc_stat_q};
      else if (addr == 4'hD)  rd_dat = temp_in;
   end

   // Strobe history resets high so a strobe held through reset is not seen as a new access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q        <= 1'b1;
         rd_q        <= 1'b1;
         acc_addr_q  <= 4'hF;
         db_oe_q     <= 1'b0;
         byte_ff_q   <= 1'b0;
         mclr_q      <= 1'b0;
         cmd_q       <= '0;
         mask_q      <= '1;
         req_q       <= '0;
         tc_stat_q   <= '0;
         mode_q      <= '0;
         base_addr_q <= '0;
         base_cnt_q  <= '0;
         curr_addr_q <= '0;
         curr_cnt_q  <= '0;
      end else begin
         wr_q        <= wr_v;
         rd_q        <= rd_v;
         acc_addr_q  <= acc_addr_d;
         db_oe_q     <= db_oe_d;
         byte_ff_q   <= byte_ff_d;
         mclr_q      <= mclr_d;
         cmd_q       <= cmd_d;
         mask_q      <= mask_d;
         req_q       <= req_d;
         tc_stat_q   <= tc_stat_d;
         mode_q      <= mode_d;
         base_addr_q <= base_addr_d;
         base_cnt_q  <= base_cnt_d;
         curr_addr_q <= curr_addr_d;
         curr_cnt_q  <= curr_cnt_d;
      end
   end

   assign db_out     = rd_dat;
   assign db_oe      = db_oe_q;
   assign cmd_reg    = cmd_q;
   assign mode_reg   = mode_q;
   assign mask_reg   = mask_q;
   assign req_reg    = req_q;
   assign curr_addr  = curr_addr_q;
   assign curr_count = curr_cnt_q;
   assign mclr_pulse = mclr_q;

endmodule

// File: tb/tb_dma_prog_if.sv
// Directed bench for dma_prog_if: host accesses, TC handling, master clear and reset mid-write.
module tb_dma_prog_if;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs_n, ior_n, iow_n;
   logic [3:0]  addr;
   logic [7:0]  db_in, db_out, temp_in, cmd_reg;
   logic        db_oe, upd_en, mclr_pulse;
   logic [3:0]  dreq_live, tc_pulse, mask_reg, req_reg;
   logic [1:0]  upd_ch;
   logic [15:0] upd_addr, upd_count;
   logic [23:0] mode_reg;
   logic [63:0] curr_addr, curr_count;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] rdat;
   logic       roe;

   dma_prog_if #(.NUM_CH(4), .ADDR_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .ior_n(ior_n), .iow_n(iow_n),
      .addr(addr), .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
      .dreq_live(dreq_live), .temp_in(temp_in), .tc_pulse(tc_pulse),
      .upd_en(upd_en), .upd_ch(upd_ch), .upd_addr(upd_addr), .upd_count(upd_count),
      .cmd_reg(cmd_reg), .mode_reg(mode_reg), .mask_reg(mask_reg), .req_reg(req_reg),
      .curr_addr(curr_addr), .curr_count(curr_count), .mclr_pulse(mclr_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic io_wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; db_in = d; cs_n = 1'b0; iow_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cs_n = 1'b1; iow_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic io_rd(input logic [3:0] a, output logic [7:0] d, output logic oe);
      @(negedge clk);
      addr = a; cs_n = 1'b0; ior_n = 1'b0;
      @(negedge clk);
      d = db_out; oe = db_oe;
      @(negedge clk);
      cs_n = 1'b1; ior_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; cs_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1; addr = 4'h0; db_in = 8'h00;
      dreq_live = 4'hA; temp_in = 8'h5C; tc_pulse = 4'h0;
      upd_en = 1'b0; upd_ch = 2'd0; upd_addr = 16'h0; upd_count = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_mask", 32'(mask_reg), 32'hF);
      chk("rst_cmd", 32'(cmd_reg), 32'h0);
      chk("rst_curr", curr_addr[31:0], 32'h0);
      chk("rst_oe", 32'(db_oe), 32'h0);
      chk("rst_mclr", 32'(mclr_pulse), 32'h0);
      reset_n = 1'b1;

      io_wr(4'hC, 8'h00);
      io_wr(4'h0, 8'h34);
      io_wr(4'h0, 8'h12);
      chk("ch0_addr", 32'(curr_addr[15:0]), 32'h1234);
      io_rd(4'h0, rdat, roe);
      chk("rd0_lo", 32'(rdat), 32'h34);
      io_rd(4'h0, rdat, roe);
      chk("rd0_hi", 32'(rdat), 32'h12);

      io_wr(4'h3, 8'hFF);
      io_wr(4'h3, 8'h00);
      chk("ch1_cnt", 32'(curr_count[31:16]), 32'h00FF);
      io_rd(4'h3, rdat, roe);
      chk("rd3_lo", 32'(rdat), 32'hFF);
      chk("rd3_oe", 32'(roe), 32'h1);
      chk("oe_idle", 32'(db_oe), 32'h0);
      io_rd(4'h3, rdat, roe);
      chk("rd3_hi", 32'(rdat), 32'h00);
      io_rd(4'hD, rdat, roe);
      chk("rd_temp", 32'(rdat), 32'h5C);

      io_wr(4'hB, 8'h56);
      chk("mode2", 32'(mode_reg[17:12]), 32'h15);
      io_wr(4'h4, 8'h00);
      io_wr(4'h4, 8'hA0);
      io_wr(4'h5, 8'h10);
      io_wr(4'h5, 8'h00);
      @(negedge clk);
      upd_en = 1'b1; upd_ch = 2'd2; upd_addr = 16'h1111; upd_count = 16'h2222;
      @(negedge clk);
      upd_en = 1'b0;
      chk("upd_addr", 32'(curr_addr[47:32]), 32'h1111);
      chk("upd_cnt", 32'(curr_count[47:32]), 32'h2222);
      io_wr(4'hA, 8'h02);
      chk("mask_single", 32'(mask_reg), 32'hB);
      io_wr(4'h9, 8'h06);
      chk("req_set", 32'(req_reg), 32'h4);
      @(negedge clk);
      tc_pulse = 4'b0100;
      @(negedge clk);
      tc_pulse = 4'b0000;
      chk("tc2_addr", 32'(curr_addr[47:32]), 32'hA000);
      chk("tc2_cnt", 32'(curr_count[47:32]), 32'h0010);
      chk("tc2_mask", 32'(mask_reg), 32'hB);
      chk("tc2_req", 32'(req_reg), 32'h0);
      io_rd(4'h8, rdat, roe);
      chk("stat_tc2", 32'(rdat), 32'hA4);
      io_rd(4'h8, rdat, roe);
      chk("stat_clr", 32'(rdat), 32'hA0);

      io_wr(4'hE, 8'h00);
      chk("mask_clr_all", 32'(mask_reg), 32'h0);
      @(negedge clk);
      tc_pulse = 4'b0001;
      @(negedge clk);
      tc_pulse = 4'b0000;
      chk("tc0_mask", 32'(mask_reg), 32'h1);
      io_rd(4'h8, rdat, roe);
      chk("stat_tc0", 32'(rdat), 32'hA1);
      io_rd(4'h8, rdat, roe);
      chk("stat_clr0", 32'(rdat), 32'hA0);

      io_wr(4'h8, 8'h5A);
      chk("cmd_wr", 32'(cmd_reg), 32'h5A);
      @(negedge clk);
      addr = 4'h8; db_in = 8'hEE; cs_n = 1'b0; iow_n = 1'b0; ior_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("wrrd_oe", 32'(db_oe), 32'h0);
      cs_n = 1'b1; iow_n = 1'b1; ior_n = 1'b1;
      @(negedge clk);
      chk("wrrd_ignored", 32'(cmd_reg), 32'h5A);

      io_wr(4'h0, 8'h77);
      @(negedge clk);
      addr = 4'hD; cs_n = 1'b0; iow_n = 1'b0;
      @(negedge clk);
      chk("mclr_pulse_hi", 32'(mclr_pulse), 32'h1);
      chk("mclr_cmd", 32'(cmd_reg), 32'h0);
      chk("mclr_mask", 32'(mask_reg), 32'hF);
      @(negedge clk);
      chk("mclr_pulse_lo", 32'(mclr_pulse), 32'h0);
      cs_n = 1'b1; iow_n = 1'b1;
      @(negedge clk);
      chk("mclr_mode_kept", 32'(mode_reg[17:12]), 32'h15);
      io_wr(4'h0, 8'h99);
      chk("mclr_ff", 32'(curr_addr[15:0]), 32'h1299);

      io_wr(4'h8, 8'h33);
      chk("cmd_33", 32'(cmd_reg), 32'h33);
      @(negedge clk);
      addr = 4'h8; db_in = 8'hFF; cs_n = 1'b0; iow_n = 1'b0; reset_n = 1'b0;
      #1;
      chk("arst_cmd", 32'(cmd_reg), 32'h0);
      chk("arst_mask", 32'(mask_reg), 32'hF);
      chk("arst_curr", 32'(curr_addr[15:0]), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst_no_commit", 32'(cmd_reg), 32'h0);
      cs_n = 1'b1; iow_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("arst_after_rel", 32'(cmd_reg), 32'h0);
      io_wr(4'h8, 8'h3C);
      chk("post_rst_wr", 32'(cmd_reg), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
